// File: rtl/mmu_defines_pkg.sv
// Shared MMU definitions: address geometry, response status codes,
// fault codes and the translation-response timeout.
package mmu_defines_pkg;

    localparam int ADDR_WIDTH        = 32;
    localparam int PAGE_OFFSET_WIDTH = 12;
    localparam int TIMEOUT           = 64;

    typedef enum logic [1:0] {
        ST_HIT        = 2'b00,
        ST_MISS       = 2'b01,
        ST_PAGE_FAULT = 2'b10
    } mmu_status_e;

    localparam logic [1:0] FAULT_PAGE    = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FWD,
        FAULT
    } xlate_state_e;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= 16'h0000;
        else if (inc && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/xlate_requester.sv
// Turns core VA accesses into MMU translation requests and forwards the
// translated PA to the cache, raising a fault pulse on page fault or timeout.
module xlate_requester #(
    parameter int ADDR_WIDTH        = mmu_defines_pkg::ADDR_WIDTH,
    parameter int PAGE_OFFSET_WIDTH = mmu_defines_pkg::PAGE_OFFSET_WIDTH,
    parameter int TIMEOUT           = mmu_defines_pkg::TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_req_valid,
    input  logic [ADDR_WIDTH-1:0] core_req_va,
    input  logic                  core_req_we,
    output logic                  core_req_ready,
    output logic                  mmu_req_valid,
    output logic [ADDR_WIDTH-1:0] mmu_req_va,
    input  logic                  mmu_req_ready,
    input  logic                  mmu_resp_valid,
    input  logic [ADDR_WIDTH-1:0] mmu_resp_pa,
    input  logic [1:0]            mmu_resp_status,
    output logic                  mmu_resp_ready,
    output logic                  cache_req_valid,
    output logic [ADDR_WIDTH-1:0] cache_req_pa,
    output logic                  cache_req_we,
    input  logic                  cache_req_ready,
    output logic                  fault_valid,
    output logic [ADDR_WIDTH-1:0] fault_va,
    output logic [1:0]            fault_code,
    output logic [15:0]           hit_cnt,
    output logic [15:0]           miss_cnt,
    output logic [15:0]           fault_cnt
);
    import mmu_defines_pkg::*;

    localparam int CNT_W     = $clog2(TIMEOUT + 1);
    localparam int PFN_WIDTH = ADDR_WIDTH - PAGE_OFFSET_WIDTH;

    xlate_state_e          state, state_nxt;
    logic [ADDR_WIDTH-1:0] va_q, pa_q;
    logic                  we_q;
    logic [1:0]            code_q, code_nxt;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  hit_inc, miss_inc, fault_inc;
    logic                  timed_out;

    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;
        fault_inc = 1'b0;
        case (state)
            IDLE:  if (core_req_valid) state_nxt = REQ;
            REQ:   if (mmu_req_ready) state_nxt = WAIT;
            WAIT: begin
                // A response on the last allowed cycle beats the timeout.
                if (mmu_resp_valid) begin
                    case (mmu_status_e'(mmu_resp_status))
                        ST_HIT:  begin hit_inc  = 1'b1; state_nxt = FWD; end
                        ST_MISS: begin miss_inc = 1'b1; state_nxt = FWD; end
                        default: begin
                            fault_inc = 1'b1;
                            code_nxt  = FAULT_PAGE;
                            state_nxt = FAULT;
                        end
                    endcase
                end else if (timed_out) begin
                    fault_inc = 1'b1;
                    code_nxt  = FAULT_TIMEOUT;
                    state_nxt = FAULT;
                end
            end
            FWD:   if (cache_req_ready) state_nxt = IDLE;
            FAULT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            va_q     <= '0;
            we_q     <= 1'b0;
            pa_q     <= '0;
            code_q   <= 2'b00;
            wait_cnt <= '0;
        end else begin
            state  <= state_nxt;
            code_q <= code_nxt;
            if (state == IDLE && core_req_valid) begin
                va_q <= core_req_va;
                we_q <= core_req_we;
            end
            if (hit_inc || miss_inc)
                pa_q <= {mmu_resp_pa[ADDR_WIDTH-1 -: PFN_WIDTH],
                         mmu_resp_pa[PAGE_OFFSET_WIDTH-1:0]};
            // Held at zero outside WAIT so every WAIT entry starts fresh.
            if (state == WAIT)
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;
        end
    end

    assign core_req_ready  = (state == IDLE);
    assign mmu_req_valid   = (state == REQ);
    assign mmu_req_va      = va_q;
    assign mmu_resp_ready  = (state == IDLE) || (state == WAIT) || (state == FAULT);
    assign cache_req_valid = (state == FWD);
    assign cache_req_pa    = pa_q;
    assign cache_req_we    = we_q;
    assign fault_valid     = (state == FAULT);
    assign fault_va        = va_q;
    assign fault_code      = code_q;

    sat_counter16 u_hit_cnt   (.clk(clk), .rst_n(rst_n), .inc(hit_inc),   .cnt(hit_cnt));
    sat_counter16 u_miss_cnt  (.clk(clk), .rst_n(rst_n), .inc(miss_inc),  .cnt(miss_cnt));
    sat_counter16 u_fault_cnt (.clk(clk), .rst_n(rst_n), .inc(fault_inc), .cnt(fault_cnt));

endmodule

// File: tb/tb_xlate_requester.sv
// Randomized scoreboard bench for xlate_requester plus a standalone
// saturation run of sat_counter16.
module tb_xlate_requester;

    localparam int AW = 32;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_req_valid = 1'b0;
    logic [AW-1:0] core_req_va = '0;
    logic          core_req_we = 1'b0;
    logic          core_req_ready;
    logic          mmu_req_valid;
    logic [AW-1:0] mmu_req_va;
    logic          mmu_req_ready = 1'b0;
    logic          mmu_resp_valid = 1'b0;
    logic [AW-1:0] mmu_resp_pa = '0;
    logic [1:0]    mmu_resp_status = 2'b00;
    logic          mmu_resp_ready;
    logic          cache_req_valid;
    logic [AW-1:0] cache_req_pa;
    logic          cache_req_we;
    logic          cache_req_ready = 1'b0;
    logic          fault_valid;
    logic [AW-1:0] fault_va;
    logic [1:0]    fault_code;
    logic [15:0]   hit_cnt, miss_cnt, fault_cnt;
    logic          sat_inc = 1'b0;
    logic [15:0]   sat_cnt;

    always #5 clk = ~clk;

    xlate_requester #(.ADDR_WIDTH(AW), .PAGE_OFFSET_WIDTH(12), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_valid(core_req_valid), .core_req_va(core_req_va),
        .core_req_we(core_req_we), .core_req_ready(core_req_ready),
        .mmu_req_valid(mmu_req_valid), .mmu_req_va(mmu_req_va),
        .mmu_req_ready(mmu_req_ready),
        .mmu_resp_valid(mmu_resp_valid), .mmu_resp_pa(mmu_resp_pa),
        .mmu_resp_status(mmu_resp_status), .mmu_resp_ready(mmu_resp_ready),
        .cache_req_valid(cache_req_valid), .cache_req_pa(cache_req_pa),
        .cache_req_we(cache_req_we), .cache_req_ready(cache_req_ready),
        .fault_valid(fault_valid), .fault_va(fault_va), .fault_code(fault_code),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .fault_cnt(fault_cnt)
    );

    sat_counter16 u_sat (.clk(clk), .rst_n(rst_n), .inc(sat_inc), .cnt(sat_cnt));

    typedef struct {
        bit            is_fault;
        logic [AW-1:0] addr;
        logic          we;
        logic [1:0]    code;
        int            hit;
        int            miss;
        int            flt;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;
    int   m_hit = 0, m_miss = 0, m_flt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bump(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Monitor: pops one expectation per cache handshake or fault pulse.
    task automatic pop_and_check();
        exp_t e;
        if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: cache_hs=%0b fault=%0b with empty scoreboard",
                     cache_req_valid && cache_req_ready, fault_valid);
            return;
        end
        e = expq.pop_front();
        check("output_kind", {cache_req_valid, fault_valid}, e.is_fault ? 2'b01 : 2'b10);
        if (e.is_fault) begin
            check("fault_va", fault_va, e.addr);
            check("fault_code", fault_code, e.code);
        end else begin
            check("cache_req_pa", cache_req_pa, e.addr);
            check("cache_req_we", cache_req_we, e.we);
        end
        check("hit_cnt", hit_cnt, e.hit);
        check("miss_cnt", miss_cnt, e.miss);
        check("fault_cnt", fault_cnt, e.flt);
    endtask

    logic          prev_mstall = 1'b0, prev_cstall = 1'b0, prev_fault = 1'b0, prev_we = 1'b0;
    logic [AW-1:0] prev_mva = '0, prev_pa = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_mstall <= 1'b0;
            prev_cstall <= 1'b0;
            prev_fault  <= 1'b0;
        end else begin
            if (prev_mstall)
                check("mmu_req_stable", {mmu_req_valid, mmu_req_va}, {1'b1, prev_mva});
            if (prev_cstall)
                check("cache_req_stable", {cache_req_valid, cache_req_we, cache_req_pa},
                      {1'b1, prev_we, prev_pa});
            if (prev_fault)
                check("fault_one_cycle", fault_valid, 1'b0);
            if (mmu_req_valid || cache_req_valid || fault_valid)
                check("core_ready_busy", core_req_ready, 1'b0);
            if ((cache_req_valid && cache_req_ready) || fault_valid)
                pop_and_check();
            prev_mstall <= mmu_req_valid && !mmu_req_ready;
            prev_cstall <= cache_req_valid && !cache_req_ready;
            prev_fault  <= fault_valid;
            prev_mva    <= mmu_req_va;
            prev_pa     <= cache_req_pa;
            prev_we     <= cache_req_we;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_and_request(input logic [AW-1:0] va, input logic we, input int mstall);
        int n;
        core_req_valid = 1'b1;
        core_req_va    = va;
        core_req_we    = we;
        n = 0;
        while (!core_req_ready && n < 100) begin tick(); n++; end
        check("core_ready_wait", core_req_ready, 1'b1);
        tick();
        core_req_valid = 1'b0;
        core_req_va    = $urandom;
        core_req_we    = ~we;
        check("mmu_req_latency", {mmu_req_valid, mmu_req_va}, {1'b1, va});
        repeat (mstall) tick();
        mmu_req_ready = 1'b1;
        tick();
        mmu_req_ready = 1'b0;
    endtask

    // kind: 0 hit, 1 miss, 2 page fault, 3 timeout (no response)
    task automatic do_txn(input int kind, input logic [AW-1:0] va, input logic we,
                          input logic [AW-1:0] pa, input int mstall, input int delay,
                          input int cstall);
        exp_t e;
        int   n;
        e.is_fault = (kind >= 2);
        e.addr     = e.is_fault ? va : pa;
        e.we       = we;
        e.code     = (kind == 2) ? 2'b10 : 2'b11;
        if (kind == 0) m_hit = bump(m_hit);
        else if (kind == 1) m_miss = bump(m_miss);
        else m_flt = bump(m_flt);
        e.hit = m_hit; e.miss = m_miss; e.flt = m_flt;
        expq.push_back(e);

        accept_and_request(va, we, mstall);
        if (kind == 3) begin
            n = 0;
            while (!fault_valid && n < TO + 20) begin tick(); n++; end
            check("timeout_cycles", n, TO);
            tick();
            // late response lands in IDLE and must vanish
            mmu_resp_valid  = 1'b1;
            mmu_resp_status = 2'b00;
            mmu_resp_pa     = $urandom;
            check("late_resp_ready", mmu_resp_ready, 1'b1);
            tick();
            mmu_resp_valid = 1'b0;
        end else begin
            repeat (delay) tick();
            mmu_resp_valid  = 1'b1;
            mmu_resp_pa     = pa;
            mmu_resp_status = (kind == 0) ? 2'b00 : (kind == 1) ? 2'b01 : 2'b10;
            check("mmu_resp_ready", mmu_resp_ready, 1'b1);
            tick();
            mmu_resp_valid = 1'b0;
            if (kind < 2) begin
                check("cache_req_latency", cache_req_valid, 1'b1);
                repeat (cstall) tick();
                cache_req_ready = 1'b1;
                tick();
                cache_req_ready = 1'b0;
            end else begin
                check("fault_latency", fault_valid, 1'b1);
                tick();
            end
        end
    endtask

    initial begin
        #1;
        check("rst_core_ready", core_req_ready, 1'b1);
        check("rst_valids", {mmu_req_valid, cache_req_valid, fault_valid}, 3'b000);
        check("rst_regs", {cache_req_pa, fault_va, fault_code}, '0);
        check("rst_cnts", {hit_cnt, miss_cnt, fault_cnt}, '0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        do_txn(0, 32'h0000_1234, 1'b1, 32'h0000_B234, 0, 0, 0);
        do_txn(1, 32'h7777_0010, 1'b0, 32'h0000_A010, 3, 2, 0);
        do_txn(2, 32'h0005_0000, 1'b1, 32'h0, 0, 1, 0);
        do_txn(3, 32'hDEAD_B000, 1'b0, 32'h0, 1, 0, 0);
        do_txn(0, 32'h1234_5678, 1'b1, 32'h9ABC_D678, 0, 0, 5);
        do_txn(1, 32'h0BAD_F00D, 1'b0, 32'h0FEE_D00D, 0, TO - 1, 1);

        for (int i = 0; i < 40; i++) begin
            int k;
            k = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            do_txn(k, $urandom, 1'($urandom), $urandom, $urandom_range(0, 4),
                   $urandom_range(0, 8), $urandom_range(0, 4));
        end

        // reset while waiting for the MMU
        accept_and_request(32'hCAFE_0000, 1'b1, 0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_valids", {mmu_req_valid, cache_req_valid, fault_valid}, 3'b000);
        check("midrst_regs", {cache_req_pa, fault_va, fault_code}, '0);
        check("midrst_cnts", {hit_cnt, miss_cnt, fault_cnt}, '0);
        m_hit = 0; m_miss = 0; m_flt = 0;
        tick();
        rst_n = 1'b1;
        check("midrst_queue_empty", expq.size(), 0);
        repeat (TO + 10) tick();
        do_txn(0, 32'h0000_2000, 1'b0, 32'h0004_2000, 0, 0, 0);
        repeat (3) tick();
        check("scoreboard_drained", expq.size(), 0);

        sat_inc = 1'b1;
        repeat (65534) tick();
        check("sat_below_max", sat_cnt, 16'hFFFE);
        repeat (3) tick();
        check("sat_hold_max", sat_cnt, 16'hFFFF);
        sat_inc = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/xlate_requester.md
XLATE_REQUESTER -- requirements
Module: xlate_requester

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  ADDR_WIDTH  32  VA/PA width
  PAGE_OFFSET_WIDTH  12  page offset bits
  TIMEOUT  64  max cycles waiting for a translation response
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk  in  1  clock
  rst_n  in  1  reset: asynchronous, active-low
  core_req_valid  in  1  core access request
  core_req_va  in  ADDR_WIDTH  virtual address
  core_req_we  in  1  1 = store, 0 = load
  core_req_ready  out  1  block accepts a core request
  mmu_req_valid  out  1  translation request to MMU
  mmu_req_va  out  ADDR_WIDTH  VA to translate
  mmu_req_ready  in  1  MMU accepts the request
  mmu_resp_valid  in  1  MMU response valid
  mmu_resp_pa  in  ADDR_WIDTH  translated PA
  mmu_resp_status  in  2  HIT / MISS / PAGE_FAULT
  mmu_resp_ready  out  1  block accepts the response
  cache_req_valid  out  1  physical access to cache controller
  cache_req_pa  out  ADDR_WIDTH  physical address
  cache_req_we  out  1  store flag, forwarded
  cache_req_ready  in  1  cache accepts
  fault_valid  out  1  one-cycle fault pulse
  fault_va  out  ADDR_WIDTH  faulting VA
  fault_code  out  2  2'b10 page fault, 2'b11 timeout
  hit_cnt, miss_cnt, fault_cnt  out  16 each  saturating statistics

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT, FWD, FAULT.
REQ-004 core_req_ready SHALL be 1 only in IDLE; a handshake there captures VA and WE and moves to REQ.
REQ-005 In REQ, mmu_req_valid SHALL be 1 and mmu_req_va SHALL equal the captured VA, both held stable until mmu_req_ready=1, then the FSM moves to WAIT.
REQ-006 mmu_resp_ready SHALL be 1 in IDLE, WAIT and FAULT; a response handshaked outside WAIT SHALL be discarded with no other effect.
REQ-007 In WAIT, a response with status HIT or MISS SHALL latch mmu_resp_pa into cache_req_pa, increment hit_cnt or miss_cnt, and move to FWD.
REQ-008 In WAIT, status PAGE_FAULT SHALL move to FAULT with fault_code=2'b10 and increment fault_cnt.
REQ-009 A WAIT cycle counter SHALL clear on entry to WAIT; if TIMEOUT cycles elapse with no response, the FSM SHALL move to FAULT with fault_code=2'b11 and increment fault_cnt.
REQ-010 A response in the same cycle the counter reaches TIMEOUT SHALL take precedence over the timeout.
REQ-011 In FWD, cache_req_valid SHALL be 1 with PA and WE stable until cache_req_ready=1, then the FSM returns to IDLE.
REQ-012 FAULT SHALL last exactly one cycle, with fault_valid=1 and fault_va equal to the captured VA, then return to IDLE; no cache request SHALL be issued.
REQ-013 Minimum latency SHALL be: core accept at cycle N, mmu_req_valid at N+1, cache_req_valid at the cycle after the response handshake.
REQ-014 Statistics counters SHALL saturate at 16'hFFFF.

Reset
REQ-015 Reset SHALL set the state to IDLE, clear all valid outputs, clear cache_req_pa, fault_va, fault_code and all counters to 0, and clear the timeout counter.
REQ-016 Reset asserted mid-transaction SHALL abandon the transaction with no pulse on fault_valid or cache_req_valid after release.

Structure
REQ-017 Status codes (HIT=2'b00, MISS=2'b01, PAGE_FAULT=2'b10), ADDR_WIDTH and PAGE_OFFSET_WIDTH SHALL come from the shared mmu_defines file; the fault codes and TIMEOUT SHALL be added there.
REQ-018 The saturating counter SHALL be one sub-module, sat_counter16, instantiated three times; all other logic stays flat.

Verification
REQ-019 Hit: core VA 0x0000_1234, MMU replies HIT with PA 0x0000_B234 -> cache_req_pa=0x0000_B234, WE preserved, hit_cnt=1.
REQ-020 Miss: MMU holds mmu_req_ready=0 for 3 cycles, then replies MISS with PA 0x0000_A010 -> mmu_req_va held stable throughout, cache_req_pa=0x0000_A010, miss_cnt=1.
REQ-021 Page fault: VA 0x0005_0000, status PAGE_FAULT -> fault_valid=1 for one cycle, fault_va=0x0005_0000, fault_code=2'b10, no cache_req_valid.
REQ-022 Timeout: no response for 64 cycles -> fault_code=2'b11; a late response then arriving in IDLE is consumed and discarded.
REQ-023 Backpressure: cache_req_ready=0 for 5 cycles -> cache_req_valid, PA and WE stable, core_req_ready stays 0 until the handshake.
REQ-024 Reset in WAIT, and counter saturation after forced 0xFFFF -> outputs return to reset values; counter stays 0xFFFF.
